// File: rtl/sp_ram_request_master.sv
// Request master for a single-port inferred RAM: turns a valid/ready request
// stream into RAM cycles and returns read data in order through a credit-limited FIFO.
module sp_ram_request_master #(
   parameter int size        = 16,
   parameter int width       = 8,
   parameter int depth       = 4,
   parameter int readLatency = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [depth-1:0] req_addr,
   input  logic [width-1:0] req_data,
   input  logic             req_write,
   input  logic             req_valid,
   output logic             req_ready,
   output logic [width-1:0] rsp_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [depth-1:0] ram_address,
   output logic [width-1:0] ram_data,
   output logic             ram_data_valid,
   input  logic [width-1:0] ram_q
);

   localparam int tail = readLatency - 1;

   logic [2:0]       outstanding;
   logic             req_fire;
   logic             read_accept;
   logic             rsp_fire;
   logic             req_oor;
   logic             issue_read;
   logic             issue_oor;
   logic [tail:0]    track_valid;
   logic [tail:0]    track_oor;
   logic             push;
   logic [width-1:0] push_data;
   logic [width-1:0] fifo_mem [4];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [2:0]       fifo_count;

   // Credit covers every read until its response is popped, so the FIFO never overflows.
   assign req_ready   = !reset && (outstanding < 3'd4);
   assign req_fire    = req_valid && req_ready;
   assign read_accept = req_fire && !req_write;
   assign rsp_fire    = rsp_valid && rsp_ready;
   assign req_oor     = int'(req_addr) >= size;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outstanding <= 3'd0;
      end else begin
         unique case ({read_accept, rsp_fire})
            2'b10:   outstanding <= outstanding + 3'd1;
            2'b01:   outstanding <= outstanding - 3'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Issue register; address and data hold when idle so only the strobe drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ram_address    <= '0;
         ram_data       <= '0;
         ram_data_valid <= 1'b0;
         issue_read     <= 1'b0;
         issue_oor      <= 1'b0;
      end else if (req_fire) begin
         ram_address    <= req_addr;
         ram_data       <= req_data;
         ram_data_valid <= req_write && !req_oor;
         issue_read     <= !req_write;
         issue_oor      <= req_oor;
      end else begin
         ram_data_valid <= 1'b0;
         issue_read     <= 1'b0;
         issue_oor      <= 1'b0;
      end
   end

   // Tracker mirrors the RAM pipeline; its tail marks the cycle ram_q holds the read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         track_valid <= '0;
         track_oor   <= '0;
      end else begin
         track_valid[0] <= issue_read;
         track_oor[0]   <= issue_oor;
         for (int i = 1; i < readLatency; i++) begin
            track_valid[i] <= track_valid[i-1];
            track_oor[i]   <= track_oor[i-1];
         end
      end
   end

   assign push      = track_valid[tail];
   assign push_data = track_oor[tail] ? '0 : ram_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         fifo_count <= 3'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= push_data;
            wr_ptr           <= wr_ptr + 2'd1;
         end
         if (rsp_fire) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         unique case ({push, rsp_fire})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign rsp_valid = (fifo_count != 3'd0);
   assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sp_ram_request_master.sv
// Directed bench for sp_ram_request_master with behavioural RAMs for
// readLatency 1 (main instance) and readLatency 2 (latency check only).
module tb_sp_ram_request_master;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_addr = '0;
   logic [7:0] req_data = '0;
   logic       req_write = 1'b0;
   logic       req_valid = 1'b0;
   logic       rsp_ready = 1'b0;
   logic       lat2_en = 1'b1;

   logic       req_ready, rsp_valid, ram_data_valid;
   logic [7:0] rsp_data, ram_data, ram_q;
   logic [3:0] ram_address;

   logic       req_valid2, req_ready2, rsp_valid2, ram_data_valid2;
   logic [7:0] rsp_data2, ram_data2, ram_q2, q2_stage;
   logic [3:0] ram_address2;

   logic [7:0] mem1 [16];
   logic [7:0] mem2 [16];
   logic [7:0] model [16];
   logic [7:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int pop_count = 0;

   assign req_valid2 = req_valid & lat2_en;

   always #5 clock = ~clock;

   sp_ram_request_master #(.size(12), .width(8), .depth(4), .readLatency(1)) dut (
      .clock(clock), .reset(reset), .req_addr(req_addr), .req_data(req_data),
      .req_write(req_write), .req_valid(req_valid), .req_ready(req_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .ram_address(ram_address), .ram_data(ram_data),
      .ram_data_valid(ram_data_valid), .ram_q(ram_q));

   sp_ram_request_master #(.size(12), .width(8), .depth(4), .readLatency(2)) dut2 (
      .clock(clock), .reset(reset), .req_addr(req_addr), .req_data(req_data),
      .req_write(req_write), .req_valid(req_valid2), .req_ready(req_ready2),
      .rsp_data(rsp_data2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
      .ram_address(ram_address2), .ram_data(ram_data2),
      .ram_data_valid(ram_data_valid2), .ram_q(ram_q2));

   // Single-port RAMs that echo write data on q, with and without output register.
   always @(posedge clock) begin
      if (ram_data_valid) mem1[ram_address] <= ram_data;
      ram_q <= ram_data_valid ? ram_data : mem1[ram_address];
   end

   always @(posedge clock) begin
      if (ram_data_valid2) mem2[ram_address2] <= ram_data2;
      q2_stage <= ram_data_valid2 ? ram_data2 : mem2[ram_address2];
      ram_q2   <= q2_stage;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock: log accepted reads into the scoreboard, check any pop, update the model.
   task automatic applyStimulus();
      if (req_valid && req_ready && !req_write)
         exp_q.push_back(req_addr >= 4'd12 ? 8'h00 : model[req_addr]);
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
         end else begin
            checkOutput("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
         end
         pop_count++;
      end
      if (req_valid && req_ready && req_write && req_addr < 4'd12)
         model[req_addr] = req_data;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      int acc;
      int base;
      int cycles;
      logic took;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;

      // Reset state
      @(negedge clock);
      checkOutput("reset_req_ready", 32'(req_ready), 0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("reset_rsp_data", 32'(rsp_data), 0);
      checkOutput("reset_ram_address", 32'(ram_address), 0);
      checkOutput("reset_ram_data", 32'(ram_data), 0);
      checkOutput("reset_ram_dv", 32'(ram_data_valid), 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("release_req_ready", 32'(req_ready), 1);
      checkOutput("release_req_ready2", 32'(req_ready2), 1);
      @(negedge clock);

      $display("[TB] write then read back, both latencies");
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd3; req_data = 8'h5A;
      applyStimulus();
      checkOutput("wr_ram_dv", 32'(ram_data_valid), 1);
      checkOutput("wr_ram_address", 32'(ram_address), 3);
      checkOutput("wr_ram_data", 32'(ram_data), 32'h5A);
      req_write = 1'b0; rsp_ready = 1'b1;
      applyStimulus();
      req_valid = 1'b0;
      checkOutput("rd_ram_dv", 32'(ram_data_valid), 0);
      checkOutput("lat1_k0_valid", 32'(rsp_valid), 0);
      applyStimulus();
      checkOutput("lat1_k1_valid", 32'(rsp_valid), 0);
      applyStimulus();
      checkOutput("lat1_k2_valid", 32'(rsp_valid), 1);
      checkOutput("lat1_k2_data", 32'(rsp_data), 32'h5A);
      checkOutput("lat2_k2_valid", 32'(rsp_valid2), 0);
      applyStimulus();
      checkOutput("lat1_k3_valid", 32'(rsp_valid), 0);
      checkOutput("lat2_k3_valid", 32'(rsp_valid2), 1);
      checkOutput("lat2_k3_data", 32'(rsp_data2), 32'h5A);
      applyStimulus();
      checkOutput("lat2_popped", 32'(rsp_valid2), 0);
      lat2_en = 1'b0;

      $display("[TB] credit limit with backpressure");
      rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr = 4'(i); req_data = 8'(8'h10 + i);
         applyStimulus();
      end
      req_write = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         req_addr = 4'(acc);
         if (req_ready) acc++;
         applyStimulus();
      end
      checkOutput("credit_accepts", 32'(acc), 4);
      checkOutput("credit_req_ready", 32'(req_ready), 0);
      req_valid = 1'b0; rsp_ready = 1'b1;
      checkOutput("drain_head_valid", 32'(rsp_valid), 1);
      checkOutput("drain_head_data", 32'(rsp_data), 32'h10);
      applyStimulus();
      checkOutput("drain_req_ready", 32'(req_ready), 1);
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("drain_empty", 32'(rsp_valid), 0);

      $display("[TB] steady read stream");
      base = pop_count;
      req_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         req_addr = 4'(i % 8);
         checkOutput("stream_req_ready", 32'(req_ready), 1);
         if (i >= 3) checkOutput("stream_rsp_valid", 32'(rsp_valid), 1);
         applyStimulus();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("stream_pops", 32'(pop_count - base), 12);

      $display("[TB] out-of-range access");
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd13; req_data = 8'hFF;
      applyStimulus();
      checkOutput("oor_ram_dv", 32'(ram_data_valid), 0);
      checkOutput("oor_ram_address", 32'(ram_address), 13);
      req_write = 1'b0;
      applyStimulus();
      req_valid = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("oor_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("oor_rsp_data", 32'(rsp_data), 0);
      applyStimulus();

      $display("[TB] reset with reads in flight");
      rsp_ready = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_addr = 4'(i);
         applyStimulus();
      end
      req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("midreset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("midreset_req_ready", 32'(req_ready), 0);
      checkOutput("midreset_ram_dv", 32'(ram_data_valid), 0);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("postreset_no_stale", 32'(rsp_valid), 0);
         applyStimulus();
      end
      base = pop_count;
      req_valid = 1'b1; req_addr = 4'd3;
      applyStimulus();
      req_valid = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("postreset_data", 32'(rsp_data), 32'h13);
      applyStimulus();
      checkOutput("postreset_pops", 32'(pop_count - base), 1);

      $display("[TB] pointer wrap with random stalls");
      acc = 0; cycles = 0; base = pop_count;
      while ((acc < 10 || (pop_count - base) < 10) && cycles < 300) begin
         req_valid = (acc < 10); req_write = 1'b0;
         req_addr = 4'((acc * 3) % 8);
         rsp_ready = 1'($urandom_range(0, 1));
         took = req_valid && req_ready;
         applyStimulus();
         if (took) acc++;
         cycles++;
      end
      req_valid = 1'b0;
      checkOutput("wrap_timeout", 32'(cycles < 300), 1);
      checkOutput("wrap_pops", 32'(pop_count - base), 10);
      checkOutput("wrap_queue_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
